// File: rtl/demux_width_conv.sv
// demux_width_conv
//   Splits DATA_IN_W-bit words into RATIO slices of DATA_OUT_W bits. Words
//   enter through a ready/valid port into a FIFO_DEPTH-word circular buffer,
//   are popped one at a time into a shift stage, and leave as registered
//   slices on a ready/valid output port.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   data_in     input word
//   valid_in    data_in valid
//   ready_in    block can accept a word this cycle (!full && !reset)
//   data_out    current slice (registered)
//   valid_out   data_out valid
//   ready_out   downstream accepts the slice
//   fifo_count  words buffered, not counting the word in the shift stage
//   idle        buffer empty and shift stage empty
//
// Shift stage FSM
//   state    | meaning
//   ST_IDLE  | no word in the shift stage, valid_out=0
//   ST_SHIFT | word register holds a word, slice idx is on data_out

module demux_width_conv #(
  parameter int DATA_IN_W  = 32,
  parameter int DATA_OUT_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_IN_W-1:0]               data_in,
  input  logic                               valid_in,
  output logic                               ready_in,
  output logic [DATA_OUT_W-1:0]              data_out,
  output logic                               valid_out,
  input  logic                               ready_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               idle
);

  localparam int RATIO = DATA_IN_W / DATA_OUT_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(RATIO);

  if (DATA_IN_W % DATA_OUT_W != 0) begin : g_err_width
    $error("demux_width_conv: DATA_IN_W must be a multiple of DATA_OUT_W");
  end
  if (RATIO < 2) begin : g_err_ratio
    $error("demux_width_conv: DATA_IN_W/DATA_OUT_W must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("demux_width_conv: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [DATA_IN_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  state_t                state_q, state_d;
  logic [DATA_IN_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_OUT_W-1:0] data_out_q, data_out_d;

  logic full;
  logic push;
  logic pop;
  logic fifo_nonempty;
  logic last_slice;
  int   slice_sel;

  assign full          = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign last_slice    = (idx_q == IDX_W'(RATIO - 1));

  // Full blocks input even when a pop is happening this cycle, so ready_in
  // depends only on registered state and reset.
  assign ready_in = !full && !reset;
  assign push     = valid_in && ready_in;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          word_d  = mem_q[rd_ptr_q];
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ready_out) begin
          if (!last_slice) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (fifo_nonempty) begin
            // Reload straight from the buffer so the output has no bubble.
            pop    = 1'b1;
            word_d = mem_q[rd_ptr_q];
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // data_out is registered: select the slice of the next word/index now.
  always_comb begin
    slice_sel  = (MSB_FIRST != 0) ? (RATIO - 1 - int'(idx_d)) : int'(idx_d);
    data_out_d = '0;
    if (state_d == ST_SHIFT) begin
      data_out_d = word_d[slice_sel*DATA_OUT_W +: DATA_OUT_W];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
    end
  end

  // Buffer storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = (state_q == ST_SHIFT);
  assign fifo_count = count_q;
  assign idle       = (state_q == ST_IDLE) && !fifo_nonempty;

endmodule

// File: tb/tb_demux_width_conv.sv
module tb_demux_width_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_out;
  logic [2:0]  fifo_count;
  logic        idle;

  logic [31:0] data_in_l;
  logic        valid_in_l, ready_in_l, valid_out_l, ready_out_l, idle_l;
  logic [7:0]  data_out_l;
  logic [2:0]  fifo_count_l;

  logic [63:0] data_in_w;
  logic        valid_in_w, ready_in_w, valid_out_w, ready_out_w, idle_w;
  logic [15:0] data_out_w;
  logic [2:0]  fifo_count_w;

  demux_width_conv u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .fifo_count(fifo_count), .idle(idle)
  );

  demux_width_conv #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in_l), .valid_in(valid_in_l),
    .ready_in(ready_in_l), .data_out(data_out_l), .valid_out(valid_out_l),
    .ready_out(ready_out_l), .fifo_count(fifo_count_l), .idle(idle_l)
  );

  demux_width_conv #(.DATA_IN_W(64), .DATA_OUT_W(16)) u_wide (
    .clk(clk), .reset(reset), .data_in(data_in_w), .valid_in(valid_in_w),
    .ready_in(ready_in_w), .data_out(data_out_w), .valid_out(valid_out_w),
    .ready_out(ready_out_w), .fifo_count(fifo_count_w), .idle(idle_w)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the default instance: every accepted word becomes
  // four bytes, most significant first, that must appear in order on the
  // output, each one held until taken.
  logic [7:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_data", data_out, prev_data);
      end
      if (exp_q.size() == 0) begin
        chk("valid_without_pending", valid_out, 0);
      end else if (valid_out && ready_out) begin
        chk("slice_order", data_out, exp_q.pop_front());
      end
      prev_hold = valid_out && !ready_out;
      prev_data = data_out;
      if (valid_in && ready_in) begin
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back(8'((data_in >> (8 * (3 - k))) & 32'hFF));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [7:0]  exp_l [4];
  logic [15:0] exp_w [4];
  int          accepted;

  initial begin
    reset       = 1'b1;
    valid_in    = 1'b1;
    data_in     = 32'hFFFF_FFFF;
    ready_out   = 1'b1;
    valid_in_l  = 1'b0;
    data_in_l   = '0;
    ready_out_l = 1'b1;
    valid_in_w  = 1'b0;
    data_in_w   = '0;
    ready_out_w = 1'b1;

    // 1: reset with an offered word
    tick();
    tick();
    chk("t1_valid_out", valid_out, 0);
    chk("t1_data_out", data_out, 8'h00);
    chk("t1_fifo_count", fifo_count, 0);
    chk("t1_idle", idle, 1);
    chk("t1_ready_in_reset", ready_in, 0);
    reset    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("t1_ready_in_release", ready_in, 1);
    tick();
    chk("t1_no_accept_count", fifo_count, 0);
    chk("t1_no_accept_valid", valid_out, 0);

    // 2: single word, one slice per cycle starting one cycle after accept
    valid_in = 1'b1;
    data_in  = 32'hAABB_CCDD;
    tick();
    valid_in = 1'b0;
    chk("t2_latency", valid_out, 0);
    tick(); chk("t2_s0", {valid_out, data_out}, {1'b1, 8'hAA});
    tick(); chk("t2_s1", {valid_out, data_out}, {1'b1, 8'hBB});
    tick(); chk("t2_s2", {valid_out, data_out}, {1'b1, 8'hCC});
    tick(); chk("t2_s3", {valid_out, data_out}, {1'b1, 8'hDD});
    tick();
    chk("t2_done_valid", valid_out, 0);
    chk("t2_done_idle", idle, 1);

    // 3: back-to-back words, no bubble between them
    valid_in = 1'b1;
    data_in  = 32'h0102_0304;
    tick();
    data_in  = 32'h0506_0708;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t3_stream", {valid_out, data_out}, {1'b1, 8'(i + 1)});
      tick();
    end
    chk("t3_done_valid", valid_out, 0);

    // 4: backpressure fills shift stage plus buffer, then drains
    ready_out = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      valid_in = 1'b1;
      data_in  = 32'(k) * 32'h1111_1111;
      #1;
      chk("t4_ready_before_full", ready_in, 1);
      tick();
    end
    data_in = 32'h6666_6666;
    #1;
    chk("t4_full_ready", ready_in, 0);
    chk("t4_full_count", fifo_count, 4);
    chk("t4_held_slice", {valid_out, data_out}, {1'b1, 8'h11});
    chk("t4_not_idle", idle, 0);
    tick();
    tick();
    chk("t4_still_full", ready_in, 0);
    ready_out = 1'b1;
    accepted  = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready_in) begin
        tick();
        accepted = 1;
        break;
      end
      tick();
    end
    valid_in = 1'b0;
    chk("t4_word6_accepted", accepted, 1);
    for (int i = 0; i < 60; i++) begin
      if (idle) break;
      tick();
    end
    chk("t4_drained_idle", idle, 1);
    chk("t4_drained_queue", exp_q.size(), 0);

    // 6: reset mid-word with one word buffered
    valid_in = 1'b1;
    data_in  = 32'hAABB_CCDD;
    tick();
    data_in  = 32'hDEAD_BEEF;
    tick();
    valid_in = 1'b0;
    chk("t6_s0", data_out, 8'hAA);
    tick(); chk("t6_s1", data_out, 8'hBB);
    tick(); chk("t6_s2", data_out, 8'hCC);
    chk("t6_buffered", fifo_count, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", valid_out, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_idle", idle, 1);
    chk("t6_rst_data", data_out, 8'h00);
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'h1234_5678;
    tick();
    valid_in = 1'b0;
    chk("t6_latency", valid_out, 0);
    tick(); chk("t6_n0", {valid_out, data_out}, {1'b1, 8'h12});
    tick(); chk("t6_n1", {valid_out, data_out}, {1'b1, 8'h34});
    tick(); chk("t6_n2", {valid_out, data_out}, {1'b1, 8'h56});
    tick(); chk("t6_n3", {valid_out, data_out}, {1'b1, 8'h78});
    tick();
    chk("t6_done_valid", valid_out, 0);

    // 5: LSB-first order and a 64->16 instance
    exp_l = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    exp_w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    valid_in_l = 1'b1;
    data_in_l  = 32'hAABB_CCDD;
    valid_in_w = 1'b1;
    data_in_w  = 64'h0001_0002_0003_0004;
    tick();
    valid_in_l = 1'b0;
    valid_in_w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_lsb_slice", {valid_out_l, data_out_l}, {1'b1, exp_l[k]});
      chk("t5_wide_slice", {valid_out_w, data_out_w}, {1'b1, exp_w[k]});
    end
    tick();
    chk("t5_lsb_idle", idle_l, 1);
    chk("t5_wide_idle", idle_w, 1);

    tick();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
